// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: FSM states, transaction owner,
// counter widths and the saturating-increment helper used by the perf counters.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } owner_t;

   localparam int RUN_W  = 4;
   localparam int PERF_W = 32;

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + PERF_W'(1);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_perf.sv
// Optional saturating transaction/stall counters for mem_bus_arbiter.
// The module exists only when MEM_ARB_PERF_EN is defined.
`ifdef MEM_ARB_PERF_EN
module mem_arb_perf
   import mem_bus_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_done,
   input  logic              data_done,
   input  logic              stall,
   output logic [PERF_W-1:0] inst_cnt,
   output logic [PERF_W-1:0] data_cnt,
   output logic [PERF_W-1:0] stall_cnt
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_cnt  <= '0;
         data_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (inst_done) inst_cnt  <= sat_inc(inst_cnt);
         if (data_done) data_cnt  <= sat_inc(data_cnt);
         if (stall)     stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing one SRAM-like bus between fetch and load/store.
// Define MEM_ARB_PERF_EN to add the perf_inst_cnt/perf_data_cnt/perf_stall_cnt outputs.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            inst_req,
   input  logic [AW-1:0]   inst_addr,
   output logic            inst_addr_ok,
   output logic            inst_data_ok,
   output logic [DW-1:0]   inst_rdata,
   input  logic            data_req,
   input  logic            data_wr,
   input  logic [DW/8-1:0] data_wstrb,
   input  logic [AW-1:0]   data_addr,
   input  logic [DW-1:0]   data_wdata,
   output logic            data_addr_ok,
   output logic            data_data_ok,
   output logic [DW-1:0]   data_rdata,
   output logic            bus_req,
   output logic            bus_wr,
   output logic [DW/8-1:0] bus_wstrb,
   output logic [AW-1:0]   bus_addr,
   output logic [DW-1:0]   bus_wdata,
   input  logic            bus_addr_ok,
   input  logic            bus_data_ok,
   input  logic [DW-1:0]   bus_rdata
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_inst_cnt,
   output logic [PERF_W-1:0] perf_data_cnt,
   output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

   state_t           state, state_nx;
   owner_t           owner, owner_nx;
   logic [RUN_W-1:0] run_cnt;
   logic             discard;
   logic             grant_inst, grant_data;
   logic             inst_kill;

   logic [AW-1:0]    addr_q;
   logic             wr_q;
   logic [DW/8-1:0]  wstrb_q;
   logic [DW-1:0]    wdata_q;

   // A flush in the same cycle as the handshake already kills the inst response.
   assign inst_kill  = flush | discard;
   assign inst_rdata = bus_rdata;
   assign data_rdata = bus_rdata;

   always_comb begin
      state_nx     = state;
      owner_nx     = owner;
      grant_inst   = 1'b0;
      grant_data   = 1'b0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      bus_req      = 1'b0;
      bus_wr       = 1'b0;
      bus_wstrb    = '0;
      bus_addr     = '0;
      bus_wdata    = '0;
      case (state)
         ST_IDLE: begin
            if (data_req && !(inst_req && run_cnt == RUN_W'(MAX_DATA_RUN)))
               grant_data = 1'b1;
            else if (inst_req)
               grant_inst = 1'b1;
            if (grant_data || grant_inst) begin
               state_nx = ST_ADDR;
               owner_nx = grant_data ? OWN_DATA : OWN_INST;
            end
         end
         ST_ADDR: begin
            bus_req   = 1'b1;
            bus_wr    = wr_q;
            bus_wstrb = wstrb_q;
            bus_addr  = addr_q;
            bus_wdata = wdata_q;
            if (bus_addr_ok) begin
               state_nx     = ST_RESP;
               inst_addr_ok = (owner == OWN_INST) && !inst_kill;
               data_addr_ok = (owner == OWN_DATA);
            end
         end
         ST_RESP: begin
            if (bus_data_ok) begin
               state_nx     = ST_IDLE;
               owner_nx     = OWN_NONE;
               inst_data_ok = (owner == OWN_INST) && !inst_kill;
               data_data_ok = (owner == OWN_DATA);
            end
         end
         default: begin
            state_nx = ST_IDLE;
            owner_nx = OWN_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         owner   <= OWN_NONE;
         run_cnt <= '0;
         discard <= 1'b0;
      end else begin
         state <= state_nx;
         owner <= owner_nx;
         if (grant_data && inst_req)
            run_cnt <= run_cnt + RUN_W'(1);
         else if (grant_inst || !inst_req)
            run_cnt <= '0;
         if (state_nx == ST_IDLE)
            discard <= 1'b0;
         else if (flush && owner == OWN_INST && state != ST_IDLE)
            discard <= 1'b1;
      end
   end

   // Request fields are only visible on the bus while in ADDR, so they need no reset.
   always_ff @(posedge clk) begin
      if (grant_data || grant_inst) begin
         addr_q  <= grant_data ? data_addr : inst_addr;
         wr_q    <= grant_data & data_wr;
         wstrb_q <= grant_data ? data_wstrb : '0;
         wdata_q <= grant_data ? data_wdata : '0;
      end
   end

`ifdef MEM_ARB_PERF_EN
   mem_arb_perf u_perf (
      .clk       (clk),
      .rst       (rst),
      .inst_done (inst_data_ok),
      .data_done (data_data_ok),
      .stall     ((inst_req && !grant_inst) || (data_req && !grant_data)),
      .inst_cnt  (perf_inst_cnt),
      .data_cnt  (perf_data_cnt),
      .stall_cnt (perf_stall_cnt)
   );
`endif

endmodule
